oclib_uart_frame_rx: RTL

- Sits directly downstream of the UART byte channel, on the rx data/valid/ready side of the UART block.
- Consumes the raw received byte stream and recovers length-prefixed, checksummed frames.
- Buffers each payload until its checksum is verified, so downstream logic only ever sees complete, valid frames.
- Bad or truncated frames are dropped, and an error pulse reports the cause.

---
 rtl/oclib_uart_pkg.sv | 20 ++
 rtl/oclib_uart_frame_rx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/oclib_uart_pkg.sv
// Shared definitions for the UART frame receiver: default delimiter,
// error pulse bit positions and the receive state encoding.
package oclib_uart_pkg;

    localparam logic [7:0] FrameSyncDefault = 8'h5A;

    localparam int FrameErrBadLen  = 0;
    localparam int FrameErrBadChk  = 1;
    localparam int FrameErrTimeout = 2;
    localparam int FrameErrorWidth = 3;

    typedef enum logic [2:0] {
        STATE_IDLE,
        STATE_LEN,
        STATE_PAYLOAD,
        STATE_CHECK,
        STATE_DRAIN
    } frame_state_e;

endpackage

// File: rtl/oclib_uart_frame_rx.sv
// Recovers SYNC/LEN/payload/CHK frames from a UART byte stream, buffering the
// payload until its checksum verifies and dropping bad frames with an error pulse.
module oclib_uart_frame_rx
    import oclib_uart_pkg::*;
#(
    parameter int unsigned MaxLen        = 16,
    parameter logic [7:0]  SyncByte      = FrameSyncDefault,
    parameter int unsigned TimeoutCycles = 1_000_000,
    parameter int unsigned ErrorWidth    = FrameErrorWidth
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            inData,
    input  logic                  inValid,
    output logic                  inReady,
    output logic [7:0]            outData,
    output logic                  outValid,
    output logic                  outLast,
    input  logic                  outReady,
    output logic [ErrorWidth-1:0] error
);

    localparam int PtrWidth   = $clog2(MaxLen + 1);
    localparam int AddrWidth  = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam int TimerWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TimerWidth-1:0] TimerLast =
        TimerWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    frame_state_e          state_q, state_d;
    logic [PtrWidth-1:0]   len_q, len_d;
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]            sum_q, sum_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic [ErrorWidth-1:0] error_q, error_d;

    logic [7:0]            mem_q [2**AddrWidth];
    logic                  mem_we;
    logic                  in_accept;
    logic                  out_xfer;
    logic [PtrWidth-1:0]   len_last;
    logic [7:0]            chk_sum;

    // Outputs are gated by reset so nothing leaks out while reset is held.
    assign inReady   = !reset && (state_q != STATE_DRAIN);
    assign outValid  = !reset && (state_q == STATE_DRAIN);
    assign outData   = mem_q[rd_ptr_q[AddrWidth-1:0]];
    assign outLast   = outValid && (rd_ptr_q == len_last);
    assign error     = reset ? '0 : error_q;

    assign in_accept = inValid && inReady;
    assign out_xfer  = outValid && outReady;
    assign len_last  = len_q - 1'b1;
    assign chk_sum   = sum_q + inData;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sum_d    = sum_q;
        timer_d  = '0;
        error_d  = '0;
        mem_we   = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                if (in_accept && (inData == SyncByte)) begin
                    state_d = STATE_LEN;
                end
            end
            STATE_LEN: begin
                if (in_accept) begin
                    if ((inData == 8'd0) || (32'(inData) > MaxLen)) begin
                        error_d[FrameErrBadLen] = 1'b1;
                        state_d                 = STATE_IDLE;
                    end else begin
                        len_d    = PtrWidth'(inData);
                        sum_d    = inData;
                        wr_ptr_d = '0;
                        state_d  = STATE_PAYLOAD;
                    end
                end
            end
            STATE_PAYLOAD: begin
                if (in_accept) begin
                    mem_we   = 1'b1;
                    sum_d    = chk_sum;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == len_last) begin
                        state_d = STATE_CHECK;
                    end
                end
            end
            STATE_CHECK: begin
                if (in_accept) begin
                    if (chk_sum == 8'd0) begin
                        rd_ptr_d = '0;
                        state_d  = STATE_DRAIN;
                    end else begin
                        error_d[FrameErrBadChk] = 1'b1;
                        state_d                 = STATE_IDLE;
                    end
                end
            end
            STATE_DRAIN: begin
                if (out_xfer) begin
                    if (outLast) begin
                        state_d = STATE_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = STATE_IDLE;
        endcase

        // The timer defaults to zero, so accepts and state entry clear it.
        if (!in_accept && ((state_q == STATE_LEN) || (state_q == STATE_PAYLOAD) ||
                           (state_q == STATE_CHECK))) begin
            if ((TimeoutCycles != 0) && (timer_q == TimerLast)) begin
                error_d                  = '0;
                error_d[FrameErrTimeout] = 1'b1;
                state_d                  = STATE_IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= STATE_IDLE;
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sum_q    <= '0;
            timer_q  <= '0;
            error_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sum_q    <= sum_d;
            timer_q  <= timer_d;
            error_q  <= error_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AddrWidth-1:0]] <= inData;
        end
    end

endmodule
